// File: rtl/sysbus_mem_responder_if.sv
// sysbus_mem_responder_if: Sysbus request/response handshake bundle.
// Signals:
//   bus_reqcyc/bus_reqack/bus_req/bus_reqtag      request channel (initiator -> responder)
//   bus_respcyc/bus_respack/bus_resp/bus_resptag  response channel (responder -> initiator)
// Modports: master = initiator side, slave = responder side.
interface sysbus_mem_responder_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);
    logic                      bus_reqcyc;
    logic                      bus_reqack;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: memory-side Sysbus responder backed by an internal 64-bit word array.
// Ports:
//   clk, reset                           clock, synchronous active-high reset
//   bus (sysbus_mem_responder_if.slave)  line requests in, 8-beat read responses out
//   i_init_we/i_init_addr/i_init_data    backdoor word write for preloading the array
// Optional: define SYSBUS_CRITICAL_WORD_FIRST_EN to start read beats at the requested word
// and wrap within the line; otherwise read beats always come out in line order.
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS_LOG2 = 16,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    sysbus_mem_responder_if.slave     bus,
    input  logic                      i_init_we,
    input  logic [MEM_WORDS_LOG2-1:0] i_init_addr,
    input  logic [63:0]               i_init_data
);
    typedef enum logic [1:0] {IDLE, RLAT, RESP, WDATA} state_t;
    state_t                    r_state, w_state_nxt;
    logic [MEM_WORDS_LOG2-1:3] r_base, w_hdr_base, w_load_base;
    logic [2:0]                r_beat, w_beat_nxt, w_load_beat, w_ord;
    logic [7:0]                r_cnt, w_cnt_nxt;
    logic [BUS_TAG_WIDTH-1:0]  r_tag, r_resptag;
    logic [BUS_DATA_WIDTH-1:0] r_resp;
    logic                      r_reqack, r_respcyc;
    logic                      w_req_xfer, w_hdr, w_load, w_wr;
    logic [BUS_DATA_WIDTH-1:0] r_mem [2**MEM_WORDS_LOG2];
    assign w_req_xfer      = bus.bus_reqcyc && r_reqack;
    assign w_hdr           = (r_state == IDLE) && w_req_xfer;
    assign w_hdr_base      = bus.bus_req[MEM_WORDS_LOG2+2:6];
    // a beat arriving in the reset cycle is dropped rather than committed
    assign w_wr            = (r_state == WDATA) && w_req_xfer && !reset;
    assign bus.bus_reqack  = r_reqack;
    assign bus.bus_respcyc = r_respcyc;
    assign bus.bus_resp    = r_resp;
    assign bus.bus_resptag = r_resptag;
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
    logic [2:0] r_start;
    // with zero latency the first word is fetched in the header cycle, before r_start is valid
    assign w_ord = w_load_beat + (w_hdr ? bus.bus_req[5:3] : r_start);
    always_ff @(posedge clk) begin
        if (reset) r_start <= 3'd0;
        else if (w_hdr) r_start <= bus.bus_req[5:3];
    end
`else
    assign w_ord = w_load_beat;
`endif
    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_load_base = w_hdr ? w_hdr_base : r_base;
        w_load_beat = 3'd0;
        case (r_state)
            IDLE: if (w_req_xfer) begin
                w_beat_nxt = 3'd0;
                if (!bus.bus_reqtag[BUS_TAG_WIDTH-1]) w_state_nxt = WDATA;
                else if (READ_LATENCY == 0) begin
                    w_state_nxt = RESP;
                    w_load      = 1'b1;
                end else begin
                    w_state_nxt = RLAT;
                    w_cnt_nxt   = 8'(READ_LATENCY);
                end
            end
            RLAT: if (r_cnt == 8'd1) begin
                w_state_nxt = RESP;
                w_load      = 1'b1;
            end else w_cnt_nxt = r_cnt - 8'd1;
            RESP: if (bus.bus_respack) begin
                if (r_beat == 3'd7) w_state_nxt = IDLE;
                else begin
                    w_beat_nxt  = r_beat + 3'd1;
                    w_load      = 1'b1;
                    w_load_beat = r_beat + 3'd1;
                end
            end
            WDATA: if (w_req_xfer) begin
                w_beat_nxt  = r_beat + 3'd1;
                w_state_nxt = (r_beat == 3'd7) ? IDLE : WDATA;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_beat    <= 3'd0;
            r_cnt     <= 8'd0;
            r_base    <= '0;
            r_tag     <= '0;
            r_reqack  <= 1'b0;
            r_respcyc <= 1'b0;
            r_resp    <= '0;
            r_resptag <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_beat    <= w_beat_nxt;
            r_cnt     <= w_cnt_nxt;
            r_reqack  <= (w_state_nxt == IDLE) || (w_state_nxt == WDATA);
            r_respcyc <= w_state_nxt == RESP;
            if (w_hdr) begin
                r_base <= w_hdr_base;
                r_tag  <= bus.bus_reqtag;
            end
            // response data is captured once per beat, so backdoor writes cannot disturb a held beat
            if (w_load) begin
                r_resp    <= r_mem[{w_load_base, w_ord}];
                r_resptag <= w_hdr ? bus.bus_reqtag : r_tag;
            end
        end
    end
    // bus write is issued last so it wins over a same-cycle backdoor write to the same word
    always_ff @(posedge clk) begin
        if (i_init_we) r_mem[i_init_addr] <= i_init_data;
        if (w_wr) r_mem[{r_base, r_beat}] <= bus.bus_req;
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: randomized self-checking bench against a word-array reference model.
module tb_sysbus_mem_responder;
    localparam int L = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_we = 1'b0;
    logic [15:0] init_addr = '0;
    logic [63:0] init_data = '0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [63:0] mdl [int];
    sysbus_mem_responder_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) bus ();
    sysbus_mem_responder #(.READ_LATENCY(L)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .i_init_we(init_we), .i_init_addr(init_addr), .i_init_data(init_data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic int word_of(logic [63:0] addr);
        return int'((addr >> 3) & 64'hFFFF);
    endfunction
    function automatic int exp_idx(logic [63:0] addr, int i);
        int w = word_of(addr);
`ifdef SYSBUS_CRITICAL_WORD_FIRST_EN
        return (w & ~7) + (((w & 7) + i) % 8);
`else
        return (w & ~7) + i;
`endif
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic preload(int idx, logic [63:0] d);
        init_we = 1'b1;
        init_addr = 16'(idx);
        init_data = d;
        tick();
        init_we = 1'b0;
        mdl[idx] = d;
    endtask
    task automatic header(logic [63:0] addr, logic [12:0] tag, output int t);
        bus.bus_reqcyc = 1'b1;
        bus.bus_req = addr;
        bus.bus_reqtag = tag;
        t = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.bus_reqack) begin
                t = cyc;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL header_accept reqack=%b expected 1", bus.bus_reqack);
        end
        tick();
        bus.bus_reqcyc = 1'b0;
        bus.bus_req = {$urandom, $urandom};
        bus.bus_reqtag = 13'($urandom);
    endtask
    task automatic read_line(logic [63:0] addr, logic [12:0] tag, int sb, int sl);
        int t;
        int beat = 0;
        int stalls = 0;
        bit started = 0;
        logic [63:0] e;
        header(addr, tag, t);
        for (int n = 0; n < 120 && beat < 8; n++) begin
            @(negedge clk);
            if (bus.bus_respcyc) begin
                if (!started) begin
                    started = 1;
                    checks++;
                    if (cyc != t + 1 + L) begin
                        errors++;
                        $display("FAIL first_beat_cycle got=%0d expected=%0d", cyc, t + 1 + L);
                    end
                end
                e = mdl[exp_idx(addr, beat)];
                checks++;
                if (bus.bus_resp !== e) begin
                    errors++;
                    $display("FAIL read_data beat=%0d got=%h expected=%h", beat, bus.bus_resp, e);
                end
                checks++;
                if (bus.bus_resptag !== tag) begin
                    errors++;
                    $display("FAIL read_tag beat=%0d got=%h expected=%h", beat, bus.bus_resptag, tag);
                end
                if (beat == sb && stalls < sl) begin
                    bus.bus_respack = 1'b0;
                    stalls++;
                end else begin
                    bus.bus_respack = 1'b1;
                    beat++;
                end
            end else begin
                bus.bus_respack = 1'($urandom_range(0, 1));
                if (started) begin
                    checks++;
                    errors++;
                    $display("FAIL read_bubble beat=%0d respcyc=0 expected 1", beat);
                end
            end
            tick();
        end
        bus.bus_respack = 1'b0;
        checks++;
        if (beat != 8) begin
            errors++;
            $display("FAIL read_complete beats=%0d expected 8", beat);
        end
        @(negedge clk);
        checks++;
        if (bus.bus_respcyc !== 1'b0 || bus.bus_reqack !== 1'b1) begin
            errors++;
            $display("FAIL read_end respcyc=%b reqack=%b expected 0 1", bus.bus_respcyc, bus.bus_reqack);
        end
        tick();
    endtask
    task automatic write_line(logic [63:0] addr, logic [12:0] tag, input logic [63:0] d [8], int gap, int coll);
        int t;
        int base = word_of(addr) & ~7;
        header(addr, tag, t);
        for (int i = 0; i < 8; i++) begin
            bus.bus_reqcyc = 1'b1;
            bus.bus_req = d[i];
            if (i == coll) begin
                init_we = 1'b1;
                init_addr = 16'(base + i);
                init_data = ~d[i];
            end
            @(negedge clk);
            checks++;
            if (bus.bus_reqack !== 1'b1 || bus.bus_respcyc !== 1'b0) begin
                errors++;
                $display("FAIL write_beat i=%0d reqack=%b respcyc=%b expected 1 0", i, bus.bus_reqack, bus.bus_respcyc);
            end
            tick();
            init_we = 1'b0;
            mdl[base + i] = d[i];
            if (i == gap) begin
                bus.bus_reqcyc = 1'b0;
                bus.bus_req = {$urandom, $urandom};
                @(negedge clk);
                checks++;
                if (bus.bus_respcyc !== 1'b0) begin
                    errors++;
                    $display("FAIL write_gap respcyc=%b expected 0", bus.bus_respcyc);
                end
                tick();
            end
        end
        bus.bus_reqcyc = 1'b0;
    endtask
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.bus_reqack, bus.bus_respcyc} !== 2'b00 || bus.bus_resp !== 64'd0 || bus.bus_resptag !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs reqack=%b respcyc=%b resp=%h tag=%h expected all 0",
                     bus.bus_reqack, bus.bus_respcyc, bus.bus_resp, bus.bus_resptag);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (bus.bus_reqack !== 1'b1 || bus.bus_respcyc !== 1'b0) begin
            errors++;
            $display("FAIL reset_release reqack=%b respcyc=%b expected 1 0", bus.bus_reqack, bus.bus_respcyc);
        end
    endtask
    task automatic test_read();
        for (int i = 0; i < 8; i++) preload(16'h40 + i, 64'h1000 + 64'(i));
        read_line(64'h200, 13'h1005, -1, 0);
        read_line(64'h218, 13'h1ABC, -1, 0);
    endtask
    task automatic test_stall();
        read_line(64'h200, 13'h1005, 2, 3);
    endtask
    task automatic test_write();
        logic [63:0] d [8];
        for (int i = 0; i < 8; i++) d[i] = 64'hA0 + 64'(i);
        write_line(64'h80, 13'h0007, d, 3, 5);
        read_line(64'h80, 13'h1007, -1, 0);
    endtask
    task automatic test_reset_mid();
        int t;
        int beat = 0;
        header(64'h200, 13'h1005, t);
        bus.bus_respack = 1'b1;
        for (int n = 0; n < 50 && beat < 4; n++) begin
            @(negedge clk);
            if (bus.bus_respcyc) beat++;
            tick();
        end
        @(negedge clk);
        bus.bus_respack = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (bus.bus_respcyc !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read respcyc=%b expected 0", bus.bus_respcyc);
        end
        reset = 1'b0;
        tick();
        read_line(64'h200, 13'h1005, -1, 0);
        for (int i = 0; i < 8; i++) preload(16'h60 + i, 64'h2000 + 64'(i));
        header(64'h300, 13'h0001, t);
        for (int i = 0; i < 3; i++) begin
            bus.bus_reqcyc = 1'b1;
            bus.bus_req = 64'hB0 + 64'(i);
            tick();
            mdl[16'h60 + i] = 64'hB0 + 64'(i);
        end
        bus.bus_req = 64'hB3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.bus_reqcyc = 1'b0;
        tick();
        read_line(64'h300, 13'h1001, -1, 0);
    endtask
    task automatic test_random();
        logic [63:0] d [8];
        logic [63:0] addr;
        for (int k = 0; k < 14; k++) begin
            int base = 8 * $urandom_range(16'h100, 16'h1FF);
            if (!mdl.exists(base) || $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
                addr = 64'(base + $urandom_range(0, 7)) << 3;
                write_line(addr, {1'b0, 12'($urandom)}, d, $urandom_range(0, 8), $urandom_range(0, 10));
            end
            addr = (64'($urandom) << 19) | (64'(base + $urandom_range(0, 7)) << 3) | 64'($urandom_range(0, 7));
            read_line(addr, {1'b1, 12'($urandom)}, $urandom_range(0, 9), $urandom_range(0, 4));
        end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.bus_reqcyc = 1'b0;
        bus.bus_req = '0;
        bus.bus_reqtag = '0;
        bus.bus_respack = 1'b0;
        test_reset();
        test_read();
        test_stall();
        test_write();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
